// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the multi-channel gated frequency meter.
// Build option: RECIPROCAL_EN adds the ARM state (gate edge-aligned to channel 0).
package freq_meter_pkg;

  localparam int unsigned DEF_NUM_CH       = 4;
  localparam int unsigned DEF_CNT_W        = 32;
  localparam int unsigned DEF_GATE_W       = 32;
  localparam int unsigned DEF_RELAX_CYCLES = 16;

  localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [2:0] {
    IDLE,
`ifdef RECIPROCAL_EN
    ARM,
`endif
    GATE,
    LATCH,
    HOLD,
    RELAX
  } meterState_e;

endpackage

// File: rtl/freq_meter_mc_if.sv
// Control/result bundle between the frequency meter and its register-side consumer.
interface freq_meter_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned GATE_W = 32
) ();

  logic                    start;
  logic                    continuous;
  logic [GATE_W-1:0]       gateCycles;
  logic                    ack;
  logic                    busy;
  logic                    valid;
  logic [CNT_W-1:0]        refCount;
  logic [NUM_CH*CNT_W-1:0] sigCount;
  logic [NUM_CH-1:0]       overflow;

  modport master (
    output start, continuous, gateCycles, ack,
    input  busy, valid, refCount, sigCount, overflow
  );

  modport slave (
    input  start, continuous, gateCycles, ack,
    output busy, valid, refCount, sigCount, overflow
  );

endinterface

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchroniser plus rising-edge detect for one asynchronous signal channel.
module freq_meter_edge_sync (
  input  logic sysClk,
  input  logic sysRst,
  input  logic sigIn,
  output logic edgePulse
);

  logic sync1, sync2, prev;

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sigIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edgePulse = sync2 & ~prev;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel gated frequency counter; all channels counted in the sysClk domain.
// Build option: RECIPROCAL_EN aligns the gate to channel-0 edges (see ARM state).
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned GATE_W       = DEF_GATE_W,
  parameter int unsigned RELAX_CYCLES = DEF_RELAX_CYCLES
) (
  input  logic              sysClk,
  input  logic              sysRst,
  input  logic [NUM_CH-1:0] signal,
  freq_meter_mc_if.slave    bus
);

  localparam int unsigned GC_W  = GATE_W + 1;
  localparam int unsigned CMP_W = (GC_W > CNT_W) ? GC_W : CNT_W;
  localparam int unsigned RL_W  = $clog2(RELAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] SAT_CNT = '1;

  meterState_e state, stateNext;

  logic [NUM_CH-1:0]       edgePulse;
  logic [GATE_W-1:0]       gateLen;
  logic [GATE_W-1:0]       gateSample;
  logic [GC_W-1:0]         gateCnt;
  logic [GC_W-1:0]         gateCntInc;
  logic [RL_W-1:0]         relaxCnt;
  logic [CNT_W-1:0]        workCnt [NUM_CH];
  logic [NUM_CH-1:0]       workOvf;
  logic [CNT_W-1:0]        refSat;
  logic [CNT_W-1:0]        refReg;
  logic [NUM_CH*CNT_W-1:0] sigReg;
  logic [NUM_CH-1:0]       ovfReg;

  logic loadMeas, gateInc, gateClr, countEn, setOvf0, doLatch;

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    freq_meter_edge_sync uSync (
      .sysClk   (sysClk),
      .sysRst   (sysRst),
      .sigIn    (signal[g]),
      .edgePulse(edgePulse[g])
    );
  end

  assign gateSample = (bus.gateCycles == '0) ? GATE_W'(1) : bus.gateCycles;
  assign gateCntInc = gateCnt + 1'b1;

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadMeas  = 1'b0;
    gateInc   = 1'b0;
    gateClr   = 1'b0;
    countEn   = 1'b0;
    setOvf0   = 1'b0;
    doLatch   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          loadMeas = 1'b1;
`ifdef RECIPROCAL_EN
          stateNext = ARM;
`else
          stateNext = GATE;
`endif
        end
      end
`ifdef RECIPROCAL_EN
      // gateCnt doubles as the ARM timeout counter and restarts when the gate opens
      ARM: begin
        gateInc = 1'b1;
        if (edgePulse[0]) begin
          gateClr   = 1'b1;
          stateNext = GATE;
        end else if (gateCntInc >= {gateLen, 1'b0}) begin
          setOvf0   = 1'b1;
          stateNext = LATCH;
        end
      end
      GATE: begin
        countEn = 1'b1;
        gateInc = 1'b1;
        if (edgePulse[0] && (gateCntInc >= GC_W'(gateLen))) begin
          stateNext = LATCH;
        end else if (gateCntInc >= {gateLen, 1'b0}) begin
          setOvf0   = 1'b1;
          stateNext = LATCH;
        end
      end
`else
      GATE: begin
        countEn = 1'b1;
        gateInc = 1'b1;
        if (gateCntInc == GC_W'(gateLen)) stateNext = LATCH;
      end
`endif
      LATCH: begin
        doLatch   = 1'b1;
        stateNext = HOLD;
      end
      HOLD: begin
        if (bus.ack) stateNext = bus.continuous ? RELAX : IDLE;
      end
      RELAX: begin
        if (relaxCnt == RL_W'(RELAX_CYCLES - 1)) begin
          loadMeas = 1'b1;
`ifdef RECIPROCAL_EN
          stateNext = ARM;
`else
          stateNext = GATE;
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    refSat = CNT_W'(gateCnt);
    if (CMP_W'(gateCnt) > CMP_W'(SAT_CNT)) refSat = SAT_CNT;
  end

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      gateLen  <= '0;
      gateCnt  <= '0;
      relaxCnt <= '0;
      workOvf  <= '0;
      refReg   <= '0;
      sigReg   <= '0;
      ovfReg   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) workCnt[i] <= '0;
    end else begin
      if (loadMeas) begin
        gateLen <= gateSample;
        gateCnt <= '0;
        workOvf <= '0;
        for (int unsigned i = 0; i < NUM_CH; i++) workCnt[i] <= '0;
      end else begin
        if (gateClr)      gateCnt <= '0;
        else if (gateInc) gateCnt <= gateCntInc;
        if (setOvf0) workOvf[0] <= 1'b1;
        // A pulse arriving at saturation is a lost count and marks the channel
        if (countEn) begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (edgePulse[i]) begin
              if (workCnt[i] == SAT_CNT) workOvf[i] <= 1'b1;
              else                       workCnt[i] <= workCnt[i] + 1'b1;
            end
          end
        end
      end
      if (state == RELAX) relaxCnt <= relaxCnt + 1'b1;
      else                relaxCnt <= '0;
      if (doLatch) begin
        refReg <= refSat;
        ovfReg <= workOvf;
        for (int unsigned i = 0; i < NUM_CH; i++) sigReg[i*CNT_W +: CNT_W] <= workCnt[i];
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.valid    = (state == HOLD);
  assign bus.refCount = refReg;
  assign bus.sigCount = sigReg;
  assign bus.overflow = ovfReg;

endmodule
